// File: rtl/periph_bridge.sv
// periph_bridge: turns a held CPU request into a single-cycle one-hot strobe to one
// peripheral, waits out the peripheral's registered read latency, and returns
// zero-extended read data with a one-cycle acknowledge. Unmapped indices complete
// with an error and no strobe.
module periph_bridge #(
    parameter int unsigned NPERIPH = 4,
    parameter int unsigned ADDR_W  = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cpu_req_i,
    input  logic                   cpu_we_i,
    input  logic [ADDR_W-1:0]      cpu_addr_i,
    input  logic [31:0]            cpu_wdata_i,
    output logic [31:0]            cpu_rdata_o,
    output logic                   cpu_ack_o,
    output logic                   cpu_err_o,
    output logic                   busy_o,
    output logic [NPERIPH-1:0]     p_ren_o,
    output logic [NPERIPH-1:0]     p_wen_o,
    output logic [7:0]             p_wdata_o,
    output logic [3:0]             p_reg_o,
    input  logic [8*NPERIPH-1:0]   p_rdata_i
);

    localparam int unsigned IdxW = ADDR_W - 4;

    typedef enum logic [1:0] {StIdle, StStrobe, StWait, StDone} state_e;

    state_e state_q, state_d;

    // Latched access attributes, held from accept until the access completes.
    logic              we_q, we_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              mapped_q, mapped_d;

    // Output registers.
    logic [NPERIPH-1:0] p_ren_q, p_ren_d;
    logic [NPERIPH-1:0] p_wen_q, p_wen_d;
    logic [7:0]         p_wdata_q, p_wdata_d;
    logic [3:0]         p_reg_q, p_reg_d;
    logic [31:0]        cpu_rdata_q, cpu_rdata_d;
    logic               cpu_ack_q, cpu_ack_d;
    logic               cpu_err_q, cpu_err_d;
    logic               busy_q, busy_d;

    logic [IdxW-1:0]    req_idx;
    logic               req_mapped;
    logic [NPERIPH-1:0] req_onehot;
    logic [7:0]         rd_byte;

    assign req_idx    = cpu_addr_i[ADDR_W-1:4];
    assign req_mapped = 32'(req_idx) < NPERIPH;

    // Decode the requested index into a one-hot peripheral select.
    always_comb begin
        req_onehot = '0;
        for (int unsigned i = 0; i < NPERIPH; i++) begin
            if (32'(req_idx) == i) begin
                req_onehot[i] = 1'b1;
            end
        end
    end

    // Pick the latched peripheral's read byte; a loop avoids out-of-range slicing.
    always_comb begin
        rd_byte = '0;
        for (int unsigned i = 0; i < NPERIPH; i++) begin
            if (32'(idx_q) == i) begin
                rd_byte = p_rdata_i[8*i +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed four-cycle walk once a request is accepted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (cpu_req_i) state_d = StStrobe;
            StStrobe: state_d = StWait;
            StWait:   state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Output and datapath next-state logic; strobes and ack are single-cycle by default.
    always_comb begin
        we_d        = we_q;
        idx_d       = idx_q;
        mapped_d    = mapped_q;
        p_ren_d     = '0;
        p_wen_d     = '0;
        p_wdata_d   = p_wdata_q;
        p_reg_d     = p_reg_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ack_d   = 1'b0;
        cpu_err_d   = 1'b0;
        busy_d      = (state_d != StIdle);

        unique case (state_q)
            StIdle: begin
                if (cpu_req_i) begin
                    we_d     = cpu_we_i;
                    idx_d    = req_idx;
                    mapped_d = req_mapped;
                    if (req_mapped) begin
                        p_wdata_d = cpu_wdata_i[7:0];
                        p_reg_d   = cpu_addr_i[3:0];
                        if (cpu_we_i) begin
                            p_wen_d = req_onehot;
                        end else begin
                            p_ren_d = req_onehot;
                        end
                    end
                end
            end
            StStrobe: begin
            end
            StWait: begin
                // Peripheral read data registered at the end of the strobe is valid now.
                cpu_ack_d   = 1'b1;
                cpu_err_d   = !mapped_q;
                cpu_rdata_d = (mapped_q && !we_q) ? {24'b0, rd_byte} : 32'b0;
            end
            StDone: begin
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q        <= 1'b0;
            idx_q       <= '0;
            mapped_q    <= 1'b0;
            p_ren_q     <= '0;
            p_wen_q     <= '0;
            p_wdata_q   <= '0;
            p_reg_q     <= '0;
            cpu_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            we_q        <= we_d;
            idx_q       <= idx_d;
            mapped_q    <= mapped_d;
            p_ren_q     <= p_ren_d;
            p_wen_q     <= p_wen_d;
            p_wdata_q   <= p_wdata_d;
            p_reg_q     <= p_reg_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_err_q   <= cpu_err_d;
            busy_q      <= busy_d;
        end
    end

    assign p_ren_o     = p_ren_q;
    assign p_wen_o     = p_wen_q;
    assign p_wdata_o   = p_wdata_q;
    assign p_reg_o     = p_reg_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign cpu_ack_o   = cpu_ack_q;
    assign cpu_err_o   = cpu_err_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_periph_bridge.sv
// Testbench for periph_bridge: directed spec cases followed by randomized accesses,
// checked against a register-array reference model of the peripheral set.
module tb_periph_bridge;

    localparam int NP = 4;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        cpu_err;
    logic        busy;
    logic [NP-1:0] p_ren;
    logic [NP-1:0] p_wen;
    logic [7:0]  p_wdata;
    logic [3:0]  p_reg;
    logic [8*NP-1:0] p_rdata;

    int checks   = 0;
    int failures = 0;
    int strobe_cycles = 0;
    int ack_count = 0;
    logic prev_ack = 1'b0;

    // Peripheral register files (environment) and the bench's reference copy.
    logic [7:0] pm      [NP][16];
    logic [7:0] ref_mem [NP][16];
    logic [7:0] rd_q    [NP];

    periph_bridge #(.NPERIPH(NP), .ADDR_W(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cpu_req_i   (cpu_req),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_rdata_o (cpu_rdata),
        .cpu_ack_o   (cpu_ack),
        .cpu_err_o   (cpu_err),
        .busy_o      (busy),
        .p_ren_o     (p_ren),
        .p_wen_o     (p_wen),
        .p_wdata_o   (p_wdata),
        .p_reg_o     (p_reg),
        .p_rdata_i   (p_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Peripheral model: one-cycle registered read, write on wen.
    always @(posedge clk) begin
        for (int i = 0; i < NP; i++) begin
            if (p_ren[i]) rd_q[i] <= pm[i][p_reg];
            if (p_wen[i]) pm[i][p_reg] <= p_wdata;
        end
    end

    always_comb begin
        for (int i = 0; i < NP; i++) p_rdata[8*i +: 8] = rd_q[i];
    end

    // Continuous exclusivity and ack-pulse checks.
    always @(negedge clk) begin
        logic [NP-1:0] any;
        any = p_ren | p_wen;
        checks = checks + 3;
        assert ((any & (any - 1'b1)) == '0) else begin
            failures++;
            $error("FAIL onehot observed=%b expected=zero_or_onehot", any);
        end
        assert ((p_ren & p_wen) == '0) else begin
            failures++;
            $error("FAIL ren_wen_overlap observed=%b expected=0", p_ren & p_wen);
        end
        assert (!(cpu_ack && prev_ack)) else begin
            failures++;
            $error("FAIL ack_two_cycles observed=1 expected=0");
        end
        prev_ack = cpu_ack;
        if (any != '0) strobe_cycles++;
        if (cpu_ack) ack_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdata"}, cpu_rdata, 32'h0);
        check({tag, "_ack"},   32'(cpu_ack), 32'h0);
        check({tag, "_err"},   32'(cpu_err), 32'h0);
        check({tag, "_busy"},  32'(busy), 32'h0);
        check({tag, "_ren"},   32'(p_ren), 32'h0);
        check({tag, "_wen"},   32'(p_wen), 32'h0);
        check({tag, "_wdata"}, 32'(p_wdata), 32'h0);
        check({tag, "_reg"},   32'(p_reg), 32'h0);
    endtask

    // One complete access starting from IDLE; hold keeps cpu_req high afterwards.
    task automatic access(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic hold, output time ack_t);
        logic [3:0]  idx;
        logic        mapped;
        logic [3:0]  exp_strb;
        logic [31:0] exp_rd;
        idx      = addr[7:4];
        mapped   = (idx < NP);
        exp_strb = mapped ? (4'b0001 << idx) : 4'b0000;
        exp_rd   = (mapped && !we) ? {24'b0, ref_mem[idx][addr[3:0]]} : 32'h0;
        if (mapped && we) ref_mem[idx][addr[3:0]] = wdata[7:0];

        @(negedge clk);
        cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
        strobe_cycles = 0;

        @(posedge clk); #1;   // E0
        check("e0_busy", 32'(busy), 32'h1);
        check("e0_ack",  32'(cpu_ack), 32'h0);
        check("e0_wen",  32'(p_wen), we ? 32'(exp_strb) : 32'h0);
        check("e0_ren",  32'(p_ren), we ? 32'h0 : 32'(exp_strb));
        if (mapped) begin
            check("e0_wdata", 32'(p_wdata), 32'(wdata[7:0]));
            check("e0_reg",   32'(p_reg), 32'(addr[3:0]));
        end

        @(posedge clk); #1;   // E1
        check("e1_strobe", 32'(p_ren | p_wen), 32'h0);
        check("e1_ack",    32'(cpu_ack), 32'h0);

        @(posedge clk); #1;   // E2
        ack_t = $time;
        check("e2_ack",   32'(cpu_ack), 32'h1);
        check("e2_err",   32'(cpu_err), 32'(!mapped));
        check("e2_rdata", cpu_rdata, exp_rd);
        check("e2_busy",  32'(busy), 32'h1);
        if (!hold) cpu_req = 1'b0;

        @(posedge clk); #1;   // E3
        check("e3_ack",   32'(cpu_ack), 32'h0);
        check("e3_err",   32'(cpu_err), 32'h0);
        check("e3_busy",  32'(busy), 32'h0);
        check("e3_rdata", cpu_rdata, exp_rd);
        check("strobe_count", 32'(strobe_cycles), mapped ? 32'h1 : 32'h0);
    endtask

    initial begin
        time t1, t2;
        int  acks_before;
        logic        r_we;
        logic [7:0]  r_addr;
        logic [31:0] r_wdata;

        for (int i = 0; i < NP; i++) begin
            for (int j = 0; j < 16; j++) begin
                pm[i][j]      = 8'($urandom);
                ref_mem[i][j] = pm[i][j];
            end
            rd_q[i] = 8'h00;
        end
        pm[2][0] = 8'hA5; ref_mem[2][0] = 8'hA5;

        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        #12;
        check_all_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Directed cases.
        access(1'b1, 8'h13, 32'hDEADBE12, 1'b0, t1);
        access(1'b0, 8'h20, 32'h0, 1'b0, t1);
        access(1'b0, 8'h50, 32'h0, 1'b0, t1);
        access(1'b1, 8'h50, 32'hFFFFFF77, 1'b0, t1);

        // Back-to-back with cpu_req held across both accesses.
        access(1'b1, 8'h00, 32'h00000005, 1'b1, t1);
        access(1'b0, 8'h00, 32'h0, 1'b0, t2);
        check("b2b_ack_spacing", 32'(t2 - t1), 32'd40);

        // Reset during WAIT of a read.
        @(negedge clk);
        cpu_we = 1'b0; cpu_addr = 8'h20; cpu_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        acks_before = ack_count;
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        repeat (2) @(posedge clk);
        #1 check("midrst_no_ack", 32'(ack_count), 32'(acks_before));
        check_all_zero("midrst_hold");
        @(posedge clk); #1 rst_n = 1'b1;
        access(1'b0, 8'h20, 32'h0, 1'b0, t1);

        // Randomized accesses against the reference model.
        for (int n = 0; n < 40; n++) begin
            r_we    = 1'($urandom);
            r_addr  = {4'($urandom_range(0, 5)), 4'($urandom)};
            r_wdata = $urandom;
            access(r_we, r_addr, r_wdata, (n != 39) ? 1'($urandom) : 1'b0, t1);
        end

        // Idle with no request: nothing must happen.
        strobe_cycles = 0;
        acks_before = ack_count;
        repeat (4) @(posedge clk);
        #1;
        check("idle_strobes", 32'(strobe_cycles), 32'h0);
        check("idle_acks", 32'(ack_count), 32'(acks_before));
        check("idle_busy", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
